// File: rtl/counter_pkg.sv
// Shared constants and helpers for the overflow counter and its prescaler.
package counter_pkg;

   localparam logic MODE_WRAP = 1'b0;
   localparam logic MODE_SAT  = 1'b1;

   localparam int DEF_WIDTH    = 4;
   localparam int DEF_PRESCALE = 1;
   localparam int DEF_WRAPW    = 8;

   typedef struct packed {
      logic ovf;
      logic udf;
   } evt_t;

   // Bits needed to hold 0..n-1; never narrower than one bit.
   function automatic int cnt_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides enabled cycles by PRESCALE; tick marks the enabled cycle that completes a period.
module tick_prescaler
   import counter_pkg::*;
#(
   parameter int PRESCALE = DEF_PRESCALE
) (
   input  logic clk,
   input  logic rst,
   input  logic adv,
   input  logic clr,
   output logic tick
);

   localparam int             PW   = cnt_bits(PRESCALE);
   localparam logic [PW-1:0]  LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] phase_q, phase_d;

   // tick is internal only; the counter registers everything it drives out.
   always_comb begin
      phase_d = phase_q;
      tick    = 1'b0;
      if (clr) begin
         phase_d = '0;
      end else if (adv) begin
         if (phase_q == LAST) begin
            tick    = 1'b1;
            phase_d = '0;
         end else begin
            phase_d = phase_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) phase_q <= '0;
      else     phase_q <= phase_d;
   end

endmodule

// File: rtl/overflow_counter.sv
// Up/down counter with wrap or saturate behaviour, overflow/underflow pulses,
// sticky flags and a saturating event counter.
module overflow_counter
   import counter_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int PRESCALE = DEF_PRESCALE,
   parameter int WRAPW    = DEF_WRAPW
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             mode,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             clr_flags,
   output logic [WIDTH-1:0] count,
   output logic             ovf_pulse,
   output logic             udf_pulse,
   output logic             ovf_sticky,
   output logic             udf_sticky,
   output logic [WRAPW-1:0] wrap_cnt
);

   localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
   localparam logic [WRAPW-1:0] WRAP_MAX = {WRAPW{1'b1}};

   logic             tick;
   logic [WIDTH-1:0] count_q, count_d;
   evt_t             evt_q, evt_d;
   logic             ovf_sticky_q, ovf_sticky_d;
   logic             udf_sticky_q, udf_sticky_d;
   logic [WRAPW-1:0] wrap_cnt_q, wrap_cnt_d;
   logic [WRAPW-1:0] wrap_base;

   // A load resets the prescaler phase and never counts as an enabled cycle.
   tick_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .adv  (en & ~load),
      .clr  (load),
      .tick (tick)
   );

   always_comb begin
      count_d = count_q;
      evt_d   = '0;
      if (load) begin
         count_d = load_val;
      end else if (tick) begin
         if (up) begin
            if (count_q == CNT_MAX) begin
               evt_d.ovf = 1'b1;
               count_d   = (mode == MODE_SAT) ? CNT_MAX : '0;
            end else begin
               count_d = count_q + 1'b1;
            end
         end else begin
            if (count_q == '0) begin
               evt_d.udf = 1'b1;
               count_d   = (mode == MODE_SAT) ? '0 : CNT_MAX;
            end else begin
               count_d = count_q - 1'b1;
            end
         end
      end
   end

   // Clear is applied first so an event in the same cycle survives it.
   always_comb begin
      ovf_sticky_d = clr_flags ? 1'b0 : ovf_sticky_q;
      udf_sticky_d = clr_flags ? 1'b0 : udf_sticky_q;
      wrap_base    = clr_flags ? '0 : wrap_cnt_q;
      wrap_cnt_d   = wrap_base;
      if (evt_d.ovf) ovf_sticky_d = 1'b1;
      if (evt_d.udf) udf_sticky_d = 1'b1;
      if ((evt_d.ovf || evt_d.udf) && (wrap_base != WRAP_MAX)) begin
         wrap_cnt_d = wrap_base + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q      <= '0;
         evt_q        <= '0;
         ovf_sticky_q <= 1'b0;
         udf_sticky_q <= 1'b0;
         wrap_cnt_q   <= '0;
      end else begin
         count_q      <= count_d;
         evt_q        <= evt_d;
         ovf_sticky_q <= ovf_sticky_d;
         udf_sticky_q <= udf_sticky_d;
         wrap_cnt_q   <= wrap_cnt_d;
      end
   end

   assign count      = count_q;
   assign ovf_pulse  = evt_q.ovf;
   assign udf_pulse  = evt_q.udf;
   assign ovf_sticky = ovf_sticky_q;
   assign udf_sticky = udf_sticky_q;
   assign wrap_cnt   = wrap_cnt_q;

endmodule
